// File: rtl/button_move_encoder.sv
// Button front end: two-flop sync, per-button debounce and press detection; C/L/R become a held move code.
// Raw edge to move_valid is DEBOUNCE_CYCLES+3 cycles; presses arriving while a move is stalled are dropped and counted.
module button_move_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btnCenter,
  input  logic       btnTop,
  input  logic       btnBottom,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_value,
  output logic       top_pulse,
  output logic       bottom_pulse,
  output logic [4:0] btn_level,
  output logic [7:0] drop_count
);

  localparam int NB = 5;
  localparam int IDX_C = 0;
  localparam int IDX_T = 1;
  localparam int IDX_B = 2;
  localparam int IDX_L = 3;
  localparam int IDX_R = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    meta_q, meta_d;
  logic [NB-1:0]    sync_q, sync_d;
  logic [NB-1:0]    stable_q, stable_d;
  logic [NB-1:0]    stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [NB-1:0]    press;

  logic       move_valid_q, move_valid_d;
  logic [1:0] move_value_q, move_value_d;
  logic       top_pulse_q, top_pulse_d;
  logic       bottom_pulse_q, bottom_pulse_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic       free;
  logic       any_move;

  assign raw = {btnRight, btnLeft, btnBottom, btnTop, btnCenter};

  // A press is the first cycle a debounced level is seen high.
  assign press = stable_q & ~stable_prev_q;

  always_comb begin
    meta_d        = raw;
    sync_d        = meta_q;
    stable_prev_d = stable_q;
    stable_d      = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    move_valid_d   = move_valid_q;
    move_value_d   = move_value_q;
    drop_count_d   = drop_count_q;
    top_pulse_d    = press[IDX_T];
    bottom_pulse_d = press[IDX_B];
    free           = !move_valid_q || move_ready;
    any_move       = press[IDX_C] || press[IDX_L] || press[IDX_R];

    if (free) begin
      if (any_move) begin
        move_valid_d = 1'b1;
        if (press[IDX_C]) begin
          move_value_d = 2'd2;
        end else if (press[IDX_L]) begin
          move_value_d = 2'd1;
        end else begin
          move_value_d = 2'd3;
        end
      end else begin
        move_valid_d = 1'b0;
        move_value_d = 2'd0;
      end
    end else if (any_move && drop_count_q != 8'hFF) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q         <= '0;
      sync_q         <= '0;
      stable_q       <= '0;
      stable_prev_q  <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
      move_valid_q   <= 1'b0;
      move_value_q   <= 2'd0;
      top_pulse_q    <= 1'b0;
      bottom_pulse_q <= 1'b0;
      drop_count_q   <= 8'd0;
    end else begin
      meta_q         <= meta_d;
      sync_q         <= sync_d;
      stable_q       <= stable_d;
      stable_prev_q  <= stable_prev_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      move_valid_q   <= move_valid_d;
      move_value_q   <= move_value_d;
      top_pulse_q    <= top_pulse_d;
      bottom_pulse_q <= bottom_pulse_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign move_valid   = move_valid_q;
  assign move_value   = move_value_q;
  assign top_pulse    = top_pulse_q;
  assign bottom_pulse = bottom_pulse_q;
  assign btn_level    = stable_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_button_move_encoder.sv
// Directed bench for button_move_encoder with a 4-cycle debounce window.
module tb_button_move_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btnCenter, btnTop, btnBottom, btnLeft, btnRight;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_value;
  logic       top_pulse, bottom_pulse;
  logic [4:0] btn_level;
  logic [7:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_move_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btnCenter    (btnCenter),
    .btnTop       (btnTop),
    .btnBottom    (btnBottom),
    .btnLeft      (btnLeft),
    .btnRight     (btnRight),
    .move_ready   (move_ready),
    .move_valid   (move_valid),
    .move_value   (move_value),
    .top_pulse    (top_pulse),
    .bottom_pulse (bottom_pulse),
    .btn_level    (btn_level),
    .drop_count   (drop_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int seen;
    int pulses;
    int pulse_at;

    reset_n    = 1'b0;
    btnCenter  = 1'b0;
    btnTop     = 1'b0;
    btnBottom  = 1'b0;
    btnLeft    = 1'b0;
    btnRight   = 1'b0;
    move_ready = 1'b0;
    tick(3);
    check_eq("rst_valid", move_valid, 0);
    check_eq("rst_value", move_value, 0);
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_pulses", {top_pulse, bottom_pulse}, 0);
    reset_n = 1'b1;
    tick(2);

    // Left press: level after 6 edges, move after 7, held while stalled.
    btnLeft = 1'b1;
    tick(5);
    check_eq("left_level_early", btn_level, 5'b00000);
    tick(1);
    check_eq("left_level", btn_level, 5'b01000);
    check_eq("left_valid_early", move_valid, 0);
    tick(1);
    check_eq("left_valid", move_valid, 1);
    check_eq("left_value", move_value, 1);
    btnLeft = 1'b0;
    tick(10);
    check_eq("left_hold_valid", move_valid, 1);
    check_eq("left_hold_value", move_value, 1);
    check_eq("left_release_level", btn_level, 5'b00000);
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    check_eq("left_accept_valid", move_valid, 0);
    check_eq("left_accept_value", move_value, 0);

    // Bouncing Center: no event until it settles high.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      btnCenter = (i % 2 == 0);
      tick(2);
      if (move_valid || btn_level[0]) seen++;
    end
    check_eq("bounce_no_event", seen, 0);
    btnCenter = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (move_valid && seen == 0) seen = i + 1;
    end
    check_eq("bounce_move_cycle", seen, 7);
    check_eq("bounce_value", move_value, 2);
    check_eq("bounce_drop", drop_count, 0);
    move_ready = 1'b1;
    btnCenter  = 1'b0;
    tick(1);
    check_eq("bounce_accept", move_valid, 0);
    tick(10);

    // Left and Right together with ready high: only Left survives.
    btnLeft  = 1'b1;
    btnRight = 1'b1;
    tick(7);
    check_eq("lr_valid", move_valid, 1);
    check_eq("lr_value", move_value, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (move_valid) seen++;
    end
    check_eq("lr_no_right", seen, 0);
    check_eq("lr_drop", drop_count, 0);
    btnLeft  = 1'b0;
    btnRight = 1'b0;
    tick(10);
    move_ready = 1'b0;

    // Pending Left, then Right is dropped.
    btnLeft = 1'b1;
    tick(7);
    check_eq("pend_value", move_value, 1);
    btnLeft = 1'b0;
    tick(10);
    btnRight = 1'b1;
    tick(7);
    check_eq("drop_value_held", move_value, 1);
    check_eq("drop_one", drop_count, 1);
    btnRight = 1'b0;
    tick(10);

    // Accept in the same cycle as a Center event: no bubble.
    btnCenter = 1'b1;
    tick(6);
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    check_eq("swap_valid", move_valid, 1);
    check_eq("swap_value", move_value, 2);
    check_eq("swap_drop", drop_count, 1);
    btnCenter = 1'b0;
    tick(10);

    // Top held: one pulse, move untouched.
    btnTop   = 1'b1;
    pulses   = 0;
    pulse_at = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (top_pulse) begin
        pulses++;
        pulse_at = i + 1;
      end
    end
    check_eq("top_pulses", pulses, 1);
    check_eq("top_pulse_cycle", pulse_at, 7);
    check_eq("top_move_valid", move_valid, 1);
    check_eq("top_move_value", move_value, 2);
    check_eq("top_drop", drop_count, 1);
    btnTop    = 1'b0;
    btnBottom = 1'b1;
    pulses    = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bottom_pulse) pulses++;
    end
    check_eq("bottom_pulses", pulses, 1);
    btnBottom = 1'b0;
    tick(10);

    // 300 dropped Right presses saturate the counter.
    for (int p = 1; p <= 300; p++) begin
      btnRight = 1'b1;
      tick(8);
      btnRight = 1'b0;
      tick(8);
      if (p == 253) check_eq("drop_254", drop_count, 254);
      if (p == 254) check_eq("drop_255", drop_count, 255);
    end
    check_eq("drop_sat", drop_count, 255);
    check_eq("drop_sat_value", move_value, 2);

    // Reset mid-debounce with a move pending, button kept held.
    btnCenter = 1'b1;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_eq("mid_rst_valid", move_valid, 0);
    check_eq("mid_rst_value", move_value, 0);
    check_eq("mid_rst_drop", drop_count, 0);
    check_eq("mid_rst_level", btn_level, 0);
    check_eq("mid_rst_pulses", {top_pulse, bottom_pulse}, 0);
    tick(5);
    check_eq("redeb_level_early", btn_level, 5'b00000);
    tick(1);
    check_eq("redeb_level", btn_level, 5'b00001);
    tick(1);
    check_eq("redeb_valid", move_valid, 1);
    check_eq("redeb_value", move_value, 2);
    check_eq("redeb_drop", drop_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_move_encoder.md
Name: button_move_encoder

Overview:
- Upstream input-conditioning stage between the raw board push-buttons and the turn-based game controller.
- Each button is synchronized, debounced and rising-edge detected.
- Left/Center/Right presses become a single held move code (1/2/3) with a valid/ready handshake, so one physical press yields exactly one move.
- Top/Bottom presses are emitted as single-cycle pulses for auxiliary controls.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronized level must differ from the stable level before it is accepted (10 ms at 100 MHz). Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-button debounce counter.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  synchronous active-low reset.
- btnCenter  input  1  raw asynchronous button, active-high.
- btnTop  input  1  raw asynchronous button, active-high.
- btnBottom  input  1  raw asynchronous button, active-high.
- btnLeft  input  1  raw asynchronous button, active-high.
- btnRight  input  1  raw asynchronous button, active-high.
- move_ready  input  1  consumer accepts the move this cycle.
- move_valid  output  1  a move is held in move_value.
- move_value  output  2  1=Left, 2=Center, 3=Right; 0 when not valid.
- top_pulse  output  1  one-cycle pulse on a debounced Top press.
- bottom_pulse  output  1  one-cycle pulse on a debounced Bottom press.
- btn_level  output  5  debounced levels {Right, Left, Bottom, Top, Center}.
- drop_count  output  8  saturating count of C/L/R presses dropped while a move was pending.

Behaviour:
- Reset: sampled only on a clk edge while reset_n=0. While reset_n=0 the block clears all synchronizer flops, stable levels, debounce counters, move_valid, move_value, pulses and drop_count to 0. A press or move in progress is discarded. There is no asynchronous path.
- Synchronizer: two flops per button. sync = second flop.
- Debounce, per button:
  - If sync == stable, the counter clears to 0.
  - Else, if counter == DEBOUNCE_CYCLES-1, stable <= sync and the counter clears to 0.
  - Else the counter increments.
  - A bounce (sync returning to stable) restarts the count.
  - Raw edge to stable change is 2 + DEBOUNCE_CYCLES cycles.
- btn_level = stable levels, registered.
- Press event: stable 0->1 on a cycle. Asserted for exactly one cycle, the cycle after stable rises. Release (1->0) generates no event.
- top_pulse and bottom_pulse: registered copies of the Top/Bottom press events. They are never gated by the move handshake.
- Move register:
  - free = !move_valid || move_ready.
  - If free and any C/L/R press event occurs: load move_value using priority Center(2) > Left(1) > Right(3), and set move_valid=1. Lower-priority simultaneous presses are discarded and not counted.
  - Else if free and no press: move_valid=0 and move_value=0.
  - If !free and any C/L/R press event occurs: move is held unchanged, and drop_count increments by 1 (saturating at 255).
  - move_valid and move_value stay stable until the accepting cycle.
  - Accept and a new press in the same cycle: the new move is loaded and move_valid stays 1, with no bubble and no drop.
- move_ready while move_valid=0 has no effect.
- Holding a button produces no repeat. A new event needs release past debounce, then press past debounce.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold btnLeft=1 from cycle 10 -> btn_level[3] rises at cycle 16; move_valid=1 with move_value=1 at cycle 17 and is held while move_ready=0.
- btnCenter toggles every 2 cycles for 20 cycles, then stays 1 -> no event during toggling; exactly one move with value 2 after stable high; drop_count=0.
- Left and Right rise in the same cycle, move_ready=1 -> one move, value 1; Right lost; drop_count unchanged.
- Move pending with move_ready=0, then a debounced Right press -> move_value stays 1 and drop_count=1. Next: move_ready=1 in the same cycle as a Center press event -> move_valid stays 1 and move_value becomes 2.
- Hold btnTop=1 for 50 cycles -> top_pulse high exactly 1 cycle; move_valid unaffected. After 300 dropped presses -> drop_count=255.
- Assert reset_n=0 for one cycle mid-debounce with a move pending -> all outputs 0 next cycle. A button still held re-debounces from scratch and generates a fresh event.
